// File: rtl/srl_dly_ctrl_if.sv
// srl_dly_ctrl_if: load handshake, data-path and SRL tap signals of the delay-line controller
interface srl_dly_ctrl_if #(
  parameter int NSTG = 4,
  parameter int DW   = 6
);
  logic            en;
  logic            ld_req;
  logic [DW-1:0]   ld_dly_m1;
  logic            ld_ack;
  logic [NSTG-1:0] srl_o;
  logic            srl_ce;
  logic [3:0]      srl_a;
  logic            d_out;
  logic            valid;
  logic            busy;
  logic [DW-1:0]   cur_dly_m1;
  modport master (
    output en, ld_req, ld_dly_m1, srl_o,
    input  ld_ack, srl_ce, srl_a, d_out, valid, busy, cur_dly_m1
  );
  modport slave (
    input  en, ld_req, ld_dly_m1, srl_o,
    output ld_ack, srl_ce, srl_a, d_out, valid, busy, cur_dly_m1
  );
endinterface

// File: rtl/srl_dly_ctrl.sv
// srl_dly_ctrl: holds the delay code of a cascaded SRL16 line, selects the tap, and blanks output while the chain refills
module srl_dly_ctrl #(
  parameter int NSTG       = 4,
  parameter int DW         = 6,
  parameter int DEF_DLY_M1 = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  srl_dly_ctrl_if.slave io
);
  localparam int TW = (DW > 4) ? DW - 4 : 1;
  typedef enum logic {FLUSH, RUN} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] fcnt_q, fcnt_d, cur_q, cur_d;
  logic [TW-1:0] tap_q, tap_d;
  logic          ack_q, ack_d, valid_q, valid_d, busy_q, busy_d;
  logic          acc, chg, done;
  // A changing load always wins over a flush completing on the same edge.
  always_comb begin
    acc     = io.ld_req && !ack_q;
    chg     = acc && (io.ld_dly_m1 != cur_q);
    done    = (state_q == FLUSH) && io.en && (fcnt_q == cur_q);
    ack_d   = acc;
    cur_d   = chg ? io.ld_dly_m1 : cur_q;
    tap_d   = chg ? TW'(io.ld_dly_m1 >> 4) : tap_q;
    state_d = chg ? FLUSH : done ? RUN : state_q;
    fcnt_d  = chg ? '0 : ((state_q == FLUSH) && io.en) ? fcnt_q + 1'b1 : fcnt_q;
    valid_d = (state_d == RUN);
    busy_d  = (state_d == FLUSH);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FLUSH;
      fcnt_q  <= '0;
      cur_q   <= DW'(DEF_DLY_M1);
      tap_q   <= TW'(DEF_DLY_M1 >> 4);
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      cur_q   <= cur_d;
      tap_q   <= tap_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end
  assign io.srl_ce     = io.en;
  assign io.srl_a      = cur_q[3:0];
  assign io.cur_dly_m1 = cur_q;
  assign io.ld_ack     = ack_q;
  assign io.valid      = valid_q;
  assign io.busy       = busy_q;
  assign io.d_out      = valid_q ? io.srl_o[tap_q] : 1'b0;
endmodule
